// File: rtl/key_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce_multi
// Brief    : N-channel key front end. Each channel has a 2-FF synchroniser,
//            a stability-counter debouncer, press/release strobes and a
//            one-shot long-press strobe. All outputs are registered.
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce_multi #(
  parameter int N_KEYS     = 4,
  parameter int DB_CNT     = 1000000,
  parameter int LONG_CNT   = 50000000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic              key_any
);

  localparam int DB_W = $clog2(DB_CNT);
  localparam int LG_W = $clog2(LONG_CNT + 1);

  localparam logic [DB_W-1:0]   c_DB_LAST = DB_W'(DB_CNT - 1);
  localparam logic [DB_W-1:0]   c_DB_ONE  = DB_W'(1);
  localparam logic [LG_W-1:0]   c_LG_MAX  = LG_W'(LONG_CNT);
  localparam logic [LG_W-1:0]   c_LG_LAST = LG_W'(LONG_CNT - 1);
  localparam logic [LG_W-1:0]   c_LG_ONE  = LG_W'(1);
  // Synchroniser idle value: the level an unpressed key drives.
  localparam logic [N_KEYS-1:0] c_IDLE    = {N_KEYS{ACTIVE_LOW}};

  logic [N_KEYS-1:0] r_sync0;
  logic [N_KEYS-1:0] r_sync1;
  logic [N_KEYS-1:0] r_state;
  logic [N_KEYS-1:0] r_press;
  logic [N_KEYS-1:0] r_release;
  logic [N_KEYS-1:0] r_long;
  logic              r_any;
  logic [DB_W-1:0]   r_db_cnt [N_KEYS];
  logic [LG_W-1:0]   r_lg_cnt [N_KEYS];

  logic [N_KEYS-1:0] w_lvl;
  logic [N_KEYS-1:0] w_accept;

  // Polarity-normalise the synchronised level and flag channels whose new
  // level has been stable long enough to be accepted this cycle.
  always_comb begin
    w_lvl    = r_sync1 ^ c_IDLE;
    w_accept = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      w_accept[i] = (w_lvl[i] != r_state[i]) && (r_db_cnt[i] == c_DB_LAST);
    end
  end

  // Two-flop synchroniser for the raw asynchronous key levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync0 <= c_IDLE;
      r_sync1 <= c_IDLE;
    end else begin
      r_sync0 <= key_in;
      r_sync1 <= r_sync0;
    end
  end

  // Per-channel debounce, strobe generation and long-press counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_long    <= '0;
      r_any     <= 1'b0;
      for (int i = 0; i < N_KEYS; i++) begin
        r_db_cnt[i] <= '0;
        r_lg_cnt[i] <= '0;
      end
    end else begin
      r_press   <= w_accept & w_lvl;
      r_release <= w_accept & ~w_lvl;
      r_any     <= |(w_accept & w_lvl);
      for (int i = 0; i < N_KEYS; i++) begin
        // Stability counter: any agreement with the accepted level restarts it.
        if (w_lvl[i] == r_state[i]) begin
          r_db_cnt[i] <= '0;
        end else if (w_accept[i]) begin
          r_db_cnt[i] <= '0;
          r_state[i]  <= w_lvl[i];
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + c_DB_ONE;
        end

        // Long-press counter: restarts on every accepted edge, so an accepted
        // release on the completing cycle suppresses the long strobe.
        r_long[i] <= 1'b0;
        if (w_accept[i] || !r_state[i]) begin
          r_lg_cnt[i] <= '0;
        end else if (r_lg_cnt[i] != c_LG_MAX) begin
          r_lg_cnt[i] <= r_lg_cnt[i] + c_LG_ONE;
          r_long[i]   <= (r_lg_cnt[i] == c_LG_LAST);
        end
      end
    end
  end

  assign key_state   = r_state;
  assign key_press   = r_press;
  assign key_release = r_release;
  assign key_long    = r_long;
  assign key_any     = r_any;

endmodule
`default_nettype wire

// File: tb/tb_key_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_debounce_multi
// Brief    : Scoreboard bench for key_debounce_multi. Two instances run in
//            parallel (active-low and active-high keys) on the same logical
//            stimulus; expected strobes are queued when keys are driven and
//            compared every cycle against both instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_debounce_multi;

  localparam int N  = 4;
  localparam int DB = 4;
  localparam int LG = 10;
  localparam int LAT = DB + 2;

  typedef struct {
    int         cyc;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] lng;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] pr = '0;
  logic [N-1:0] key_in_lo;
  logic [N-1:0] key_in_hi;
  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  ev_t sb[$];
  logic [N-1:0] exp_state = '0;

  logic [N-1:0] lo_state, lo_press, lo_rel, lo_long;
  logic [N-1:0] hi_state, hi_press, hi_rel, hi_long;
  logic lo_any, hi_any;

  assign key_in_lo = ~pr;
  assign key_in_hi = pr;

  key_debounce_multi #(.N_KEYS(N), .DB_CNT(DB), .LONG_CNT(LG), .ACTIVE_LOW(1'b1)) u_lo (
    .clk(clk), .rst_n(rst_n), .key_in(key_in_lo),
    .key_state(lo_state), .key_press(lo_press), .key_release(lo_rel),
    .key_long(lo_long), .key_any(lo_any));

  key_debounce_multi #(.N_KEYS(N), .DB_CNT(DB), .LONG_CNT(LG), .ACTIVE_LOW(1'b0)) u_hi (
    .clk(clk), .rst_n(rst_n), .key_in(key_in_hi),
    .key_state(hi_state), .key_press(hi_press), .key_release(hi_rel),
    .key_long(hi_long), .key_any(hi_any));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
  endtask

  task automatic push_ev(input int c, input logic [N-1:0] p, input logic [N-1:0] r,
                         input logic [N-1:0] l);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r; e.lng = l;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Per-cycle monitor: gather events due this cycle, compare both instances.
  always @(negedge clk) begin
    logic [N-1:0] ep, er, el;
    ep = '0; er = '0; el = '0;
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].cyc == cyc) begin
        ep |= sb[k].press; er |= sb[k].rel; el |= sb[k].lng;
        sb.delete(k);
      end else if (sb[k].cyc < cyc) begin
        check("stale_event", 32'(sb[k].cyc), 32'(cyc));
        sb.delete(k);
      end
    end
    exp_state = (exp_state | ep) & ~er;
    check("lo.state", 32'(lo_state), 32'(exp_state));
    check("lo.press", 32'(lo_press), 32'(ep));
    check("lo.release", 32'(lo_rel), 32'(er));
    check("lo.long", 32'(lo_long), 32'(el));
    check("lo.any", 32'(lo_any), 32'(|ep));
    check("hi.state", 32'(hi_state), 32'(exp_state));
    check("hi.press", 32'(hi_press), 32'(ep));
    check("hi.release", 32'(hi_rel), 32'(er));
    check("hi.long", 32'(hi_long), 32'(el));
    check("hi.any", 32'(hi_any), 32'(|ep));
  end

  initial begin
    int t;
    tick(4);
    rst_n = 1'b1;
    tick(3);

    // Clean press / release on channel 0.
    pr[0] = 1'b1; push_ev(cyc + LAT, 4'b0001, '0, '0);
    tick(8);
    pr[0] = 1'b0; push_ev(cyc + LAT, '0, 4'b0001, '0);
    tick(12);

    // Bounce on channel 1: never stable for DB cycles, so nothing accepted.
    pr[1] = 1'b1; tick(3);
    pr[1] = 1'b0; tick(1);
    pr[1] = 1'b1; tick(2);
    pr[1] = 1'b0; tick(10);
    // Then a steady press.
    pr[1] = 1'b1; push_ev(cyc + LAT, 4'b0010, '0, '0);
    tick(10);
    pr[1] = 1'b0; push_ev(cyc + LAT, '0, 4'b0010, '0);
    tick(12);

    // Long press on channel 2: long strobe exactly LG cycles after press, once.
    pr[2] = 1'b1; t = cyc;
    push_ev(t + LAT, 4'b0100, '0, '0);
    push_ev(t + LAT + LG, '0, '0, 4'b0100);
    tick(60);
    pr[2] = 1'b0; push_ev(cyc + LAT, '0, 4'b0100, '0);
    tick(12);

    // Short press on channel 3: released before the long count completes.
    pr[3] = 1'b1; push_ev(cyc + LAT, 4'b1000, '0, '0);
    tick(8);
    pr[3] = 1'b0; push_ev(cyc + LAT, '0, 4'b1000, '0);
    tick(12);

    // Release accepted on the very cycle the long count completes: suppressed.
    pr[3] = 1'b1; push_ev(cyc + LAT, 4'b1000, '0, '0);
    tick(LG);
    pr[3] = 1'b0; push_ev(cyc + LAT, '0, 4'b1000, '0);
    tick(12);

    // One cycle longer: long fires, release follows one cycle later.
    pr[3] = 1'b1; t = cyc;
    push_ev(t + LAT, 4'b1000, '0, '0);
    push_ev(t + LAT + LG, '0, '0, 4'b1000);
    tick(LG + 1);
    pr[3] = 1'b0; push_ev(cyc + LAT, '0, 4'b1000, '0);
    tick(12);

    // Simultaneous press on channels 0 and 3.
    pr = 4'b1001; push_ev(cyc + LAT, 4'b1001, '0, '0);
    tick(8);
    pr = 4'b0000; push_ev(cyc + LAT, '0, 4'b1001, '0);
    tick(12);

    // Reset mid-debounce with channel 0 held through reset.
    pr[0] = 1'b1;
    tick(4);
    rst_n = 1'b0;
    sb.delete();
    exp_state = '0;
    #1;
    check("rst.lo_out", 32'({lo_state, lo_press, lo_rel, lo_long, 3'b000, lo_any}), 32'd0);
    check("rst.hi_out", 32'({hi_state, hi_press, hi_rel, hi_long, 3'b000, hi_any}), 32'd0);
    tick(3);
    rst_n = 1'b1; t = cyc;
    push_ev(t + LAT, 4'b0001, '0, '0);
    push_ev(t + LAT + LG, '0, '0, 4'b0001);
    tick(20);
    pr[0] = 1'b0; push_ev(cyc + LAT, '0, 4'b0001, '0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 50 && sb.size() != 0; k++) tick(1);
    tick(2);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
